// File: rtl/usbf_function_ctrl.sv
// Wishbone master that initialises a usbf function core after reset and then
// services its interrupt lines by reading INT_SRC (and EP0_INT when flagged).
module usbf_function_ctrl #(
    parameter int unsigned ADDR_W      = 18,
    parameter logic [31:0] FA_VAL      = 32'h0000_0000,
    parameter logic [31:0] INT_MSK_VAL = 32'h01FF_01FF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    output logic [ADDR_W-1:0] wb_addr_o,
    output logic [31:0]       wb_data_o,
    input  logic [31:0]       wb_data_i,
    input  logic              wb_ack_i,
    output logic              wb_we_o,
    output logic              wb_stb_o,
    output logic              wb_cyc_o,
    input  logic              inta_i,
    input  logic              intb_i
);

    localparam logic [ADDR_W-1:0] ADDR_FA      = ADDR_W'(32'h04);
    localparam logic [ADDR_W-1:0] ADDR_INT_MSK = ADDR_W'(32'h08);
    localparam logic [ADDR_W-1:0] ADDR_INT_SRC = ADDR_W'(32'h0C);
    localparam logic [ADDR_W-1:0] ADDR_EP0_INT = ADDR_W'(32'h44);

    typedef enum logic [3:0] {
        ST_INIT0_ISS,
        ST_INIT0_GAP,
        ST_INIT1_ISS,
        ST_INIT1_GAP,
        ST_IDLE,
        ST_SRC_ISS,
        ST_SRC_GAP,
        ST_EP0_ISS,
        ST_EP0_GAP
    } state_e;

    state_e            state_q, state_d;
    logic [31:0]       int_src_q, int_src_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       data_q, data_d;
    logic              we_q, we_d;
    logic              cyc_q, cyc_d;
    logic              acked;
    logic              unused_int_src;

    // An ack only counts while our own cycle is on the bus.
    assign acked = cyc_q & wb_ack_i;

    // Only bit 0 (EP0 pending) steers the sequence; the rest is captured for visibility.
    assign unused_int_src = ^int_src_q[31:1];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_INIT0_ISS;
            int_src_q <= 32'h0;
            addr_q    <= '0;
            data_q    <= 32'h0;
            we_q      <= 1'b0;
            cyc_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            int_src_q <= int_src_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            we_q      <= we_d;
            cyc_q     <= cyc_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        int_src_d = int_src_q;
        unique case (state_q)
            ST_INIT0_ISS: if (acked) state_d = ST_INIT0_GAP;
            ST_INIT0_GAP: state_d = ST_INIT1_ISS;
            ST_INIT1_ISS: if (acked) state_d = ST_INIT1_GAP;
            ST_INIT1_GAP: state_d = ST_IDLE;
            ST_IDLE:      if (inta_i | intb_i) state_d = ST_SRC_ISS;
            ST_SRC_ISS: begin
                if (acked) begin
                    state_d   = ST_SRC_GAP;
                    int_src_d = wb_data_i;
                end
            end
            ST_SRC_GAP:   state_d = int_src_q[0] ? ST_EP0_ISS : ST_IDLE;
            ST_EP0_ISS:   if (acked) state_d = ST_EP0_GAP;
            ST_EP0_GAP:   state_d = ST_IDLE;
            default:      state_d = ST_INIT0_ISS;
        endcase
    end

    // Bus outputs are decoded from the next state so they register alongside it.
    always_comb begin
        addr_d = '0;
        data_d = 32'h0;
        we_d   = 1'b0;
        cyc_d  = 1'b0;
        unique case (state_d)
            ST_INIT0_ISS: begin
                addr_d = ADDR_FA;
                data_d = FA_VAL;
                we_d   = 1'b1;
                cyc_d  = 1'b1;
            end
            ST_INIT1_ISS: begin
                addr_d = ADDR_INT_MSK;
                data_d = INT_MSK_VAL;
                we_d   = 1'b1;
                cyc_d  = 1'b1;
            end
            ST_SRC_ISS: begin
                addr_d = ADDR_INT_SRC;
                cyc_d  = 1'b1;
            end
            ST_EP0_ISS: begin
                addr_d = ADDR_EP0_INT;
                cyc_d  = 1'b1;
            end
            default: begin
                addr_d = '0;
                cyc_d  = 1'b0;
            end
        endcase
    end

    assign wb_addr_o = addr_q;
    assign wb_data_o = data_q;
    assign wb_we_o   = we_q;
    assign wb_stb_o  = cyc_q;
    assign wb_cyc_o  = cyc_q;

endmodule

// File: tb/tb_usbf_function_ctrl.sv
// Scoreboard bench for usbf_function_ctrl: a randomised slave/interrupt driver
// pushes expected bus transfers and cycle checks; a monitor pops and compares.
module tb_usbf_function_ctrl;

    localparam int unsigned ADDR_W = 18;
    localparam logic [ADDR_W-1:0] A_FA  = 18'h04;
    localparam logic [ADDR_W-1:0] A_MSK = 18'h08;
    localparam logic [ADDR_W-1:0] A_SRC = 18'h0C;
    localparam logic [ADDR_W-1:0] A_EP0 = 18'h44;
    localparam logic [31:0] FA_VAL  = 32'h0000_0000;
    localparam logic [31:0] MSK_VAL = 32'h01FF_01FF;

    localparam int ID_RST  = 0;
    localparam int ID_REL  = 1;
    localparam int ID_GAP  = 2;
    localparam int ID_NEXT = 3;
    localparam int ID_IDLE = 4;
    localparam int ID_LAT  = 5;
    localparam int ID_TO   = 6;

    logic              clk = 1'b0;
    logic              rst_i, wb_ack_i, inta_i, intb_i;
    logic [31:0]       wb_data_i;
    logic [ADDR_W-1:0] wb_addr_o;
    logic [31:0]       wb_data_o;
    logic              wb_we_o, wb_stb_o, wb_cyc_o;

    always #5 clk = ~clk;

    usbf_function_ctrl #(
        .ADDR_W(ADDR_W), .FA_VAL(FA_VAL), .INT_MSK_VAL(MSK_VAL)
    ) dut (
        .clk_i(clk), .rst_i(rst_i),
        .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o), .wb_data_i(wb_data_i),
        .wb_ack_i(wb_ack_i), .wb_we_o(wb_we_o), .wb_stb_o(wb_stb_o),
        .wb_cyc_o(wb_cyc_o), .inta_i(inta_i), .intb_i(intb_i)
    );

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic              we;
        logic [31:0]       data;
    } tx_t;

    typedef struct {
        int   stamp;
        int   kind;   // 0: cyc level check, 1: scoreboard drained
        logic val;
        int   id;
    } chk_t;

    tx_t  exp_q[$];
    chk_t chk_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc_cnt = 0;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    function automatic string id_name(input int id);
        case (id)
            ID_RST:  return "reset_outputs_zero";
            ID_REL:  return "release_to_cyc";
            ID_GAP:  return "cyc_drop_on_ack";
            ID_NEXT: return "ack_to_next_cyc";
            ID_IDLE: return "idle_quiet";
            ID_LAT:  return "int_to_cyc";
            default: return "ack_wait_timeout";
        endcase
    endfunction

    // Reference model: what the bus should carry, in transfer order.
    task automatic push_write(input logic [ADDR_W-1:0] a, input logic [31:0] d);
        exp_q.push_back('{a, 1'b1, d});
    endtask

    task automatic push_read(input logic [ADDR_W-1:0] a);
        exp_q.push_back('{a, 1'b0, 32'h0});
    endtask

    task automatic expect_cyc(input logic v, input int id);
        chk_q.push_back('{cyc_cnt + 1, 0, v, id});
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Monitor: scoreboard on each transfer start, stability/idle checks, timed checks.
    tx_t  cur;
    tx_t  e;
    chk_t c;
    logic prev_cyc = 1'b0;

    always @(negedge clk) begin
        checks++;
        if (wb_cyc_o && !prev_cyc) begin
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_transfer: addr=%h we=%b data=%h, required no transfer",
                         wb_addr_o, wb_we_o, wb_data_o);
            end else begin
                e = exp_q.pop_front();
                if (wb_addr_o !== e.addr || wb_we_o !== e.we || wb_data_o !== e.data || wb_stb_o !== 1'b1) begin
                    errors++;
                    $display("FAIL transfer: addr=%h we=%b data=%h stb=%b, required addr=%h we=%b data=%h stb=1",
                             wb_addr_o, wb_we_o, wb_data_o, wb_stb_o, e.addr, e.we, e.data);
                end
            end
            cur = '{wb_addr_o, wb_we_o, wb_data_o};
        end else if (wb_cyc_o) begin
            if (wb_addr_o !== cur.addr || wb_we_o !== cur.we || wb_data_o !== cur.data || wb_stb_o !== 1'b1) begin
                errors++;
                $display("FAIL hold_stable: addr=%h we=%b data=%h stb=%b, required addr=%h we=%b data=%h stb=1",
                         wb_addr_o, wb_we_o, wb_data_o, wb_stb_o, cur.addr, cur.we, cur.data);
            end
        end else begin
            if (wb_stb_o !== 1'b0 || wb_we_o !== 1'b0 || wb_addr_o !== '0 || wb_data_o !== 32'h0) begin
                errors++;
                $display("FAIL idle_outputs: stb=%b we=%b addr=%h data=%h, required all 0",
                         wb_stb_o, wb_we_o, wb_addr_o, wb_data_o);
            end
        end
        prev_cyc = wb_cyc_o;

        while (chk_q.size() > 0 && chk_q[0].stamp <= cyc_cnt) begin
            c = chk_q.pop_front();
            checks++;
            if (c.kind == 0) begin
                if (wb_cyc_o !== c.val) begin
                    errors++;
                    $display("FAIL %s: cyc=%b, required %b", id_name(c.id), wb_cyc_o, c.val);
                end
            end else if (exp_q.size() != 0) begin
                errors++;
                $display("FAIL scoreboard_drain: %0d transfers outstanding, required 0", exp_q.size());
            end
        end
    end

    // Slave side: wait (bounded) for a cycle, stall lat cycles, ack for one cycle.
    task automatic do_ack(input logic [31:0] rd, input int lat, input bit drop_int);
        int n;
        n = 0;
        while (wb_cyc_o !== 1'b1 && n < 2000) begin
            tick();
            n++;
        end
        if (wb_cyc_o !== 1'b1) begin
            expect_cyc(1'b1, ID_TO);
            tick();
            return;
        end
        repeat (lat) tick();
        wb_data_i = rd;
        wb_ack_i  = 1'b1;
        if (drop_int) begin
            inta_i = 1'b0;
            intb_i = 1'b0;
        end
        expect_cyc(1'b0, ID_GAP);
        tick();
        wb_ack_i  = 1'b0;
        wb_data_i = $urandom();
    endtask

    task automatic apply_reset(input int cycles);
        rst_i = 1'b1;
        repeat (cycles) begin
            expect_cyc(1'b0, ID_RST);
            tick();
        end
        exp_q.delete();
        rst_i = 1'b0;
        expect_cyc(1'b1, ID_REL);
        push_write(A_FA, FA_VAL);
        push_write(A_MSK, MSK_VAL);
    endtask

    // One interrupt service; the line stays high for 'passes' INT_SRC reads.
    task automatic service(input bit a, input bit b, input logic [31:0] src, input int passes);
        inta_i = a;
        intb_i = b;
        for (int p = 0; p < passes; p++) begin
            push_read(A_SRC);
            if (src[0]) push_read(A_EP0);
            if (p == 0) expect_cyc(1'b1, ID_LAT);
            do_ack(src, $urandom_range(0, 3), p == passes - 1);
            if (src[0]) do_ack($urandom(), $urandom_range(0, 3), 1'b0);
        end
        repeat ($urandom_range(1, 4)) tick();
    endtask

    initial begin
        int sel;
        rst_i     = 1'b1;
        wb_ack_i  = 1'b0;
        wb_data_i = 32'h0;
        inta_i    = 1'b0;
        intb_i    = 1'b0;

        apply_reset(2);
        do_ack($urandom(), 6, 1'b0);
        expect_cyc(1'b1, ID_NEXT);
        tick();
        do_ack($urandom(), 0, 1'b0);
        repeat (22) begin
            expect_cyc(1'b0, ID_IDLE);
            tick();
        end

        service(1'b1, 1'b0, 32'h0000_0001, 1);
        service(1'b0, 1'b1, 32'h0000_0002, 1);
        repeat (5) begin
            expect_cyc(1'b0, ID_IDLE);
            tick();
        end

        for (int i = 0; i < 30; i++) begin
            sel = $urandom_range(0, 2);
            service(sel != 1, sel != 0, $urandom(), $urandom_range(1, 2));
        end

        // Reset while the INT_MSK write is stalled, with intb held through init.
        apply_reset(1);
        do_ack($urandom(), $urandom_range(0, 3), 1'b0);
        expect_cyc(1'b1, ID_NEXT);
        tick();
        repeat (3) tick();
        apply_reset(2);
        intb_i = 1'b1;
        do_ack($urandom(), 2, 1'b0);
        do_ack($urandom(), 1, 1'b0);
        push_read(A_SRC);
        do_ack(32'h0000_0010, 1, 1'b1);
        repeat (10) begin
            expect_cyc(1'b0, ID_IDLE);
            tick();
        end

        chk_q.push_back('{cyc_cnt + 1, 1, 1'b0, 0});
        tick();
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
